// File: rtl/ps2kb_rx_controller.sv
`default_nettype none
// ============================================================================
// Module      : ps2kb_rx_controller
// Description : Sits between the PS/2 receive shift register and the XT
//               keyboard port. Queues received scancodes in a small FIFO,
//               presents the head byte with an IRQ, and throttles the keyboard
//               by holding the PS/2 clock low when the FIFO is nearly full, on
//               host request, or after a receive error to force a retransmit.
//               Optional feature macro: PS2KB_CTRL_ERROR_RETRY_EN enables the
//               post-error clock-inhibit state and its cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2kb_rx_controller #(
    parameter int          fifo_depth     = 8,
    parameter logic [15:0] inhibit_cycles = 16'd2000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       rx_error,
    input  logic       host_ack,
    input  logic       host_flush,
    input  logic       host_clock_hold,
    output logic       shift_reset,
    output logic       ps2_clock_inhibit,
    output logic [7:0] data_out,
    output logic       irq,
    output logic       overflow,
    output logic [7:0] error_count
);

    localparam int c_aw = $clog2(fifo_depth);
    localparam int c_pw = c_aw + 1;
    // Pointers differing only in their MSB means the FIFO is full.
    localparam logic [c_pw-1:0] c_full_diff = c_pw'(fifo_depth);
    // One slot is kept free for a byte the keyboard may already be sending.
    localparam logic [c_pw-1:0] c_near_full = c_pw'(fifo_depth - 1);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ERR_INHIBIT = 2'd1,
        ST_HOST_HOLD   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [7:0]      r_mem [fifo_depth];
    logic [c_pw-1:0] r_wr_ptr;
    logic [c_pw-1:0] r_rd_ptr;
    logic [c_pw-1:0] w_wr_next;
    logic [c_pw-1:0] w_rd_next;
    logic [c_pw-1:0] w_count_next;

    logic            w_empty;
    logic            w_full;
    logic            w_rx_good;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_empty_next;
    logic [7:0]      w_head_next;

`ifdef PS2KB_CTRL_ERROR_RETRY_EN
    logic [15:0]     r_cnt;
    logic [15:0]     w_cnt_next;
`else
    // The inhibit length only matters when the retry state is built.
    logic            w_unused_inhibit;
    assign w_unused_inhibit = ^inhibit_cycles;
`endif

    // FIFO bookkeeping: pop before push so a full FIFO can accept on an ack.
    always_comb begin
        w_empty   = (r_wr_ptr == r_rd_ptr);
        w_full    = ((r_wr_ptr ^ r_rd_ptr) == c_full_diff);
        // An error in the same cycle voids the byte; flush ignores everything.
        w_rx_good = rx_valid && !rx_error && !host_flush;
        w_pop     = host_ack && !w_empty && !host_flush;
        w_push    = w_rx_good && (!w_full || w_pop);
        w_drop    = w_rx_good && w_full && !w_pop;

        w_wr_next = r_wr_ptr;
        w_rd_next = r_rd_ptr;
        if (host_flush) begin
            w_wr_next = '0;
            w_rd_next = '0;
        end else begin
            if (w_pop) begin
                w_rd_next = r_rd_ptr + c_pw'(1);
            end
            if (w_push) begin
                w_wr_next = r_wr_ptr + c_pw'(1);
            end
        end

        w_count_next = w_wr_next - w_rd_next;
        w_empty_next = (w_wr_next == w_rd_next);

        // Registered head: bypass the byte being written when it becomes head.
        if (w_empty_next) begin
            w_head_next = 8'h00;
        end else if (w_push && (w_rd_next == r_wr_ptr)) begin
            w_head_next = rx_byte;
        end else begin
            w_head_next = r_mem[w_rd_next[c_aw-1:0]];
        end
    end

    // Next-state logic: host hold/flush dominates, then error retry handling.
    always_comb begin
        w_state_next = r_state;
`ifdef PS2KB_CTRL_ERROR_RETRY_EN
        w_cnt_next   = r_cnt;
`endif
        if (host_clock_hold || host_flush) begin
            w_state_next = ST_HOST_HOLD;
        end else begin
            case (r_state)
                ST_IDLE: begin
`ifdef PS2KB_CTRL_ERROR_RETRY_EN
                    if (rx_error) begin
                        w_state_next = ST_ERR_INHIBIT;
                        w_cnt_next   = 16'd0;
                    end
`endif
                end
                ST_ERR_INHIBIT: begin
`ifdef PS2KB_CTRL_ERROR_RETRY_EN
                    if (rx_error) begin
                        w_cnt_next = 16'd0;
                    end else if (r_cnt == (inhibit_cycles - 16'd1)) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_cnt_next = r_cnt + 16'd1;
                    end
`else
                    w_state_next = ST_IDLE;
`endif
                end
                ST_HOST_HOLD: begin
                    w_state_next = ST_IDLE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

`ifdef PS2KB_CTRL_ERROR_RETRY_EN
    // Inhibit-duration counter for the error retry window.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end
`endif

    // FIFO storage; contents need no reset since the pointers qualify them.
    always_ff @(negedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= rx_byte;
        end
    end

    // FIFO pointers.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
        end
    end

    // Registered host-facing and keyboard-facing outputs.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            shift_reset       <= 1'b1;
            ps2_clock_inhibit <= 1'b0;
            data_out          <= 8'h00;
            irq               <= 1'b0;
            overflow          <= 1'b0;
            error_count       <= 8'h00;
        end else begin
            shift_reset       <= (w_state_next != ST_IDLE);
            ps2_clock_inhibit <= (w_state_next != ST_IDLE) ||
                                 (w_count_next >= c_near_full);
            data_out          <= w_head_next;
            irq               <= !w_empty_next && !host_flush;
            if (host_flush) begin
                overflow <= 1'b0;
            end else if (w_drop) begin
                overflow <= 1'b1;
            end
            if (rx_error && (error_count != 8'hFF)) begin
                error_count <= error_count + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2kb_rx_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2kb_rx_controller
// Description : Scoreboard bench for ps2kb_rx_controller. A queue-based model
//               predicts the outputs after every active (falling) edge; a
//               separate monitor compares them at the following rising edge.
//               Follows PS2KB_CTRL_ERROR_RETRY_EN to pick the expected
//               error-retry behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2kb_rx_controller;

    localparam int c_depth = 8;
    localparam int c_inh   = 20;
`ifdef PS2KB_CTRL_ERROR_RETRY_EN
    localparam bit c_retry = 1'b1;
`else
    localparam bit c_retry = 1'b0;
`endif

    logic       clock = 1'b1;
    logic       reset = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_error = 1'b0;
    logic       host_ack = 1'b0;
    logic       host_flush = 1'b0;
    logic       host_clock_hold = 1'b0;
    logic       shift_reset;
    logic       ps2_clock_inhibit;
    logic [7:0] data_out;
    logic       irq;
    logic       overflow;
    logic [7:0] error_count;

    ps2kb_rx_controller #(
        .fifo_depth     (c_depth),
        .inhibit_cycles (16'(c_inh))
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .rx_byte           (rx_byte),
        .rx_valid          (rx_valid),
        .rx_error          (rx_error),
        .host_ack          (host_ack),
        .host_flush        (host_flush),
        .host_clock_hold   (host_clock_hold),
        .shift_reset       (shift_reset),
        .ps2_clock_inhibit (ps2_clock_inhibit),
        .data_out          (data_out),
        .irq               (irq),
        .overflow          (overflow),
        .error_count       (error_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         tag;
        logic [7:0] data;
        logic       irq;
        logic       inh;
        logic       srst;
        logic       ovf;
        logic [7:0] errc;
    } exp_t;

    exp_t expq[$];
    exp_t e_cur;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    // Behavioural model state.
    logic [7:0] m_q[$];
    bit         m_ovf      = 1'b0;
    int         m_errc     = 0;
    bit         m_held     = 1'b0;
    int         m_err_left = 0;

    // Count active edges so expectations can be tagged with their edge.
    always @(negedge clock) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %h expected %h", nm, cyc, act, exp_v);
        end
    endfunction

    // Monitor: compare every expectation due at this edge.
    always @(posedge clock) begin
        while (expq.size() > 0 && expq[0].tag <= cyc) begin
            e_cur = expq.pop_front();
            if (e_cur.tag != cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL stale_expectation: got edge %0d required %0d", cyc, e_cur.tag);
            end else begin
                chk("data_out", data_out, e_cur.data);
                chk("irq", {7'd0, irq}, {7'd0, e_cur.irq});
                chk("ps2_clock_inhibit", {7'd0, ps2_clock_inhibit}, {7'd0, e_cur.inh});
                chk("shift_reset", {7'd0, shift_reset}, {7'd0, e_cur.srst});
                chk("overflow", {7'd0, overflow}, {7'd0, e_cur.ovf});
                chk("error_count", error_count, e_cur.errc);
            end
        end
    end

    // Apply one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input bit v, input logic [7:0] b, input bit e,
                        input bit a, input bit f, input bit h);
        exp_t x;
        @(negedge clock);
        #1;
        rx_valid = v; rx_byte = b; rx_error = e;
        host_ack = a; host_flush = f; host_clock_hold = h;

        if (e && m_errc < 255) m_errc++;
        if (f) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (a && m_q.size() > 0) void'(m_q.pop_front());
            if (v && !e) begin
                if (m_q.size() < c_depth) m_q.push_back(b);
                else m_ovf = 1'b1;
            end
        end
        if (h || f) begin
            m_held = 1'b1;
            m_err_left = 0;
        end else if (m_held) begin
            m_held = 1'b0;
            m_err_left = 0;
        end else if (c_retry && e) begin
            m_err_left = c_inh;
        end else if (m_err_left > 0) begin
            m_err_left--;
        end

        x.tag  = cyc + 1;
        x.data = (m_q.size() > 0) ? m_q[0] : 8'h00;
        x.irq  = (m_q.size() > 0) && !f;
        x.srst = m_held || (m_err_left > 0);
        x.inh  = x.srst || (m_q.size() >= c_depth - 1);
        x.ovf  = m_ovf;
        x.errc = 8'(m_errc);
        expq.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_values();
        chk("rst_shift_reset", {7'd0, shift_reset}, 8'd1);
        chk("rst_inhibit", {7'd0, ps2_clock_inhibit}, 8'd0);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_irq", {7'd0, irq}, 8'd0);
        chk("rst_overflow", {7'd0, overflow}, 8'd0);
        chk("rst_error_count", error_count, 8'h00);
    endtask

    // Asynchronous reset between edges, then resume from an empty model.
    task automatic mid_reset();
        #2;
        reset = 1'b1;
        rx_valid = 1'b0; rx_error = 1'b0; host_ack = 1'b0;
        host_flush = 1'b0; host_clock_hold = 1'b0;
        #1;
        check_reset_values();
        expq.delete();
        m_q.delete();
        m_ovf = 1'b0; m_errc = 0; m_held = 1'b0; m_err_left = 0;
        @(negedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        #1;
        check_reset_values();
        reset = 1'b0;

        // Single byte in, then acknowledged.
        step(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Fill to near-full, full, then one dropped byte.
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        // Full FIFO with simultaneous push and ack.
        step(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // Single error and its inhibit window; error beats a valid byte.
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(c_inh + 4);

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(c_inh + 4);

        // Host hold with queued bytes, then flush, then release.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 99) < 45, 8'($urandom), $urandom_range(0, 199) < 3,
                 $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 3);
        end
        idle(c_inh + 2);

        // Reset in the middle of an inhibit window with bytes queued.
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);
        mid_reset();
        idle(3);
        step(1'b1, 8'h2A, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Allow the monitor to drain; leftovers mean a missed comparison.
        repeat (3) @(negedge clock);
        #6;
        if (expq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2kb_rx_controller.md
# ps2kb_rx_controller

Sequencing and buffering controller that sits between the PS/2 receive shift register and the XT keyboard port logic (8255 port A / IRQ1). It accepts byte and error strobes from the shift register, queues scancodes in a small FIFO, and presents the FIFO head to the host with an IRQ. It throttles the keyboard by inhibiting the PS/2 clock line when the FIFO is nearly full, on host request, or after a framing/parity error to force a retransmit.

## Interface
- `fifo_depth`, default 8: FIFO entries; power of two, 4..64.
- `inhibit_cycles`, default 16'd2000: clock cycles the PS/2 clock is held low after an error (must cover at least 100 us).
- `clock`  in  1: system clock; all flops on falling edge.
- `reset`  in  1: asynchronous, active-high.
- `rx_byte`  in  8: received byte from the shift register, valid with `rx_valid`.
- `rx_valid`  in  1: one-cycle pulse, byte received with good parity and stop bit.
- `rx_error`  in  1: one-cycle pulse, framing/parity/timeout error.
- `host_ack`  in  1: one-cycle pulse; host consumed the head byte.
- `host_flush`  in  1: level; empties the FIFO and holds the receiver.
- `host_clock_hold`  in  1: level; host forces the keyboard clock low (keyboard reset).
- `shift_reset`  out  1: reset to the shift register.
- `ps2_clock_inhibit`  out  1: drives the PS/2 clock low (open-drain enable).
- `data_out`  out  8: FIFO head; 8'h00 when empty.
- `irq`  out  1: high while the FIFO is non-empty and `host_flush` is low.
- `overflow`  out  1: sticky; a byte was dropped because the FIFO was full.
- `error_count`  out  8: saturating count of `rx_error` pulses.

## Operation
- FIFO: read/write pointers are log2(`fifo_depth`)+1 bits wide and wrap naturally. Full when the pointers differ only in the MSB; empty when equal.
- Push on `rx_valid` when not full, or when full with `host_ack` in the same cycle (pop first, then push). A push while full without a pop drops the byte and sets `overflow`.
- Pop on `host_ack` when not empty. `host_ack` while empty is ignored.
- `host_flush` high: pointers cleared every cycle, `overflow` cleared, pushes ignored, `irq` low.
- States:
  - **IDLE**: inhibit follows the near-full rule only.
  - **ERR_INHIBIT**: inhibit and `shift_reset` high; counter runs from 0 to `inhibit_cycles`-1, then the state returns to IDLE.
  - **HOST_HOLD**: inhibit and `shift_reset` high.
- Transitions and priority: `host_clock_hold` or `host_flush` sends any state to HOST_HOLD. Deassertion of both returns to IDLE the next cycle. `rx_error` in IDLE enters ERR_INHIBIT. `rx_error` in ERR_INHIBIT restarts the counter.
- Near-full rule: in IDLE, `ps2_clock_inhibit` = (count ≥ `fifo_depth`-1). This reserves one slot for a byte already in flight.
- `error_count` increments on every `rx_error` in every state and saturates at 8'hFF.

## Timing
- Reset values: `ps2_clock_inhibit`=0, `shift_reset`=1 during reset then 0, `data_out`=8'h00, `irq`=0, `overflow`=0, `error_count`=0, state IDLE, FIFO empty.
- All outputs are registered.
- `irq` and `data_out` update on the edge after a push into an empty FIFO (1-cycle latency).
- After `host_ack`, `data_out` shows the next entry on the following edge.
- `rx_valid` and `rx_error` in the same cycle: the error wins and no push occurs.
- `rx_error` causes `ps2_clock_inhibit` to rise on the next edge. It stays high for exactly `inhibit_cycles` cycles, unless the near-full rule keeps it high afterwards.
- Reset mid-inhibit aborts immediately to IDLE with an empty FIFO.

## Configuration
- `PS2KB_CTRL_ERROR_RETRY_EN` defined: the ERR_INHIBIT state and its counter exist as described.
- Not defined: `rx_error` only increments `error_count`. The state never leaves IDLE or HOST_HOLD, and `inhibit_cycles` is unused.

## Test plan
- Reset, then push 8'h1C → the next edge gives `irq`=1 and `data_out`=8'h1C. `host_ack` → `irq`=0 and `data_out`=8'h00.
- `fifo_depth`=8, push 7 bytes with no ack → `ps2_clock_inhibit`=1 after the 7th. The 8th push is accepted; a 9th push sets `overflow`=1 and the head is unchanged.
- Full FIFO with `rx_valid` and `host_ack` in the same cycle → count stays 8, head advances, and the new byte lands at the tail.
- `inhibit_cycles`=20, `rx_error` pulse → inhibit and `shift_reset` high for exactly 20 cycles and `error_count`=1. Rebuild without the macro → no inhibit and `error_count`=1.
- 300 `rx_error` pulses → `error_count` holds 8'hFF.
- `host_clock_hold` high while 3 bytes are queued → inhibit=1 and `shift_reset`=1. Assert `host_flush` → `irq`=0 and FIFO empty. Release both → IDLE with inhibit=0 on the next edge.
